// File: rtl/mdu_if.sv
// Operand/command and HI/LO result bundle between the E-stage and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdu_op, A, B, input busy, hi, lo);
    modport slave  (input start, mdu_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; results are computed at the start edge
// and parked in shadow registers until the busy window expires.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        busy_r;
    logic [31:0] hi_r, lo_r, sh_hi, sh_lo;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_q, div_r, divu_q, divu_r;
    op_t         op;

    assign op     = op_t'(bus.mdu_op);
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

    // Divide by zero yields the current HI/LO so the commit leaves them unchanged.
    always_comb begin
        div_q  = lo_r;
        div_r  = hi_r;
        divu_q = lo_r;
        divu_r = hi_r;
        if (bus.B != '0) begin
            divu_q = bus.A / bus.B;
            divu_r = bus.A % bus.B;
            if (bus.A == 32'h8000_0000 && bus.B == '1) begin
                div_q = 32'h8000_0000;
                div_r = '0;
            end else begin
                div_q = $signed(bus.A) / $signed(bus.B);
                div_r = $signed(bus.A) % $signed(bus.B);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            sh_hi  <= '0;
            sh_lo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                {sh_hi, sh_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                                cnt    <= CW'(MULT_CYCLES);
                                busy_r <= 1'b1;
                                state  <= MUL_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                sh_hi  <= (op == OP_DIV) ? div_r : divu_r;
                                sh_lo  <= (op == OP_DIV) ? div_q : divu_q;
                                cnt    <= CW'(DIV_CYCLES);
                                busy_r <= 1'b1;
                                state  <= DIV_BUSY;
                            end
                            OP_MTHI: hi_r <= bus.A;
                            OP_MTLO: lo_r <= bus.A;
                            default: ;
                        endcase
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi_r   <= sh_hi;
                        lo_r   <= sh_lo;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
